// File: rtl/blend_rmw_sequencer_if.sv
// rtl/blend_rmw_sequencer_if.sv - pixel, VRAM and blend-datapath signal bundle for the RMW sequencer
interface blend_rmw_sequencer_if #(
   parameter int ADDR_W = 19,
   parameter int CNT_W  = 16
);
   logic              pix_valid;
   logic              pix_ready;
   logic [ADDR_W-1:0] pix_addr;
   logic [7:0]        pix_r, pix_g, pix_b;
   logic              pix_stp;
   logic              noblend;
   logic [1:0]        mode;
   logic              check_mask;
   logic              force_mask;

   logic              rd_req;
   logic              rd_ack;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [15:0]       rd_data;

   logic [7:0]        bg_r, bg_g, bg_b;
   logic [7:0]        px_r, px_g, px_b;
   logic              dp_noblend;
   logic [1:0]        dp_mode;
   logic [7:0]        bl_r, bl_g, bl_b;

   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   logic              discard;
   logic [CNT_W-1:0]  wr_count;
   logic [CNT_W-1:0]  drop_count;
   logic              busy;

   modport slave (
      input  pix_valid, pix_addr, pix_r, pix_g, pix_b, pix_stp, noblend, mode,
             check_mask, force_mask, rd_ack, rd_valid, rd_data, bl_r, bl_g, bl_b, wr_ack,
      output pix_ready, rd_req, rd_addr, bg_r, bg_g, bg_b, px_r, px_g, px_b,
             dp_noblend, dp_mode, wr_req, wr_addr, wr_data, discard, wr_count,
             drop_count, busy
   );

   modport master (
      output pix_valid, pix_addr, pix_r, pix_g, pix_b, pix_stp, noblend, mode,
             check_mask, force_mask, rd_ack, rd_valid, rd_data, bl_r, bl_g, bl_b, wr_ack,
      input  pix_ready, rd_req, rd_addr, bg_r, bg_g, bg_b, px_r, px_g, px_b,
             dp_noblend, dp_mode, wr_req, wr_addr, wr_data, discard, wr_count,
             drop_count, busy
   );
endinterface

// File: rtl/blend_rmw_sequencer.sv
// rtl/blend_rmw_sequencer.sv - read-modify-write sequencer for blended / mask-checked VRAM pixel writes
module blend_rmw_sequencer #(
   parameter int ADDR_W = 19,
   parameter int CNT_W  = 16
) (
   input logic                 clk,
   input logic                 rst,
   blend_rmw_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RDREQ, RDWAIT, BLEND, WRITE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] l_addr;
   logic [7:0]        fg_r, fg_g, fg_b;
   logic              l_stp, l_noblend, l_check, l_force;
   logic [1:0]        l_mode;
   logic [15:0]       bg;
   logic [7:0]        res_r, res_g, res_b;
   logic              discard_q;
   logic [CNT_W-1:0]  wr_cnt, drop_cnt;
   logic              accept, need_read, mask_hit;

   assign accept    = bus.pix_valid && (state == IDLE);
   assign need_read = ~bus.noblend | bus.check_mask;
   assign mask_hit  = l_check & bus.rd_data[15];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.pix_ready = 1'b0;
      bus.rd_req    = 1'b0;
      bus.wr_req    = 1'b0;
      case (state)
         IDLE: begin
            bus.pix_ready = 1'b1;
            if (bus.pix_valid) state_nx = need_read ? RDREQ : WRITE;
         end
         RDREQ: begin
            bus.rd_req = 1'b1;
            if (bus.rd_ack) state_nx = RDWAIT;
         end
         RDWAIT: if (bus.rd_valid) state_nx = mask_hit ? IDLE : BLEND;
         BLEND:  state_nx = WRITE;
         WRITE: begin
            bus.wr_req = 1'b1;
            if (bus.wr_ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_addr    <= '0;
         fg_r      <= '0;
         fg_g      <= '0;
         fg_b      <= '0;
         l_stp     <= 1'b0;
         l_noblend <= 1'b0;
         l_check   <= 1'b0;
         l_force   <= 1'b0;
         l_mode    <= '0;
         bg        <= '0;
         res_r     <= '0;
         res_g     <= '0;
         res_b     <= '0;
         discard_q <= 1'b0;
         wr_cnt    <= '0;
         drop_cnt  <= '0;
      end else begin
         discard_q <= 1'b0;
         if (accept) begin
            l_addr    <= bus.pix_addr;
            fg_r      <= bus.pix_r;
            fg_g      <= bus.pix_g;
            fg_b      <= bus.pix_b;
            l_stp     <= bus.pix_stp;
            l_noblend <= bus.noblend;
            l_check   <= bus.check_mask;
            l_force   <= bus.force_mask;
            l_mode    <= bus.mode;
         end
         // Read data only counts while a read is outstanding; stray rd_valid elsewhere is ignored.
         if (state == RDWAIT && bus.rd_valid) begin
            bg <= bus.rd_data;
            if (mask_hit) begin
               discard_q <= 1'b1;
               drop_cnt  <= drop_cnt + 1'b1;
            end
         end
         if (state == BLEND) begin
            res_r <= bus.bl_r;
            res_g <= bus.bl_g;
            res_b <= bus.bl_b;
         end
         if (state == WRITE && bus.wr_ack) wr_cnt <= wr_cnt + 1'b1;
      end
   end

   // Opaque writes (including mask-only reads) keep the foreground colour untouched by the datapath.
   logic [4:0] out_r, out_g, out_b;
   assign out_r = l_noblend ? fg_r[7:3] : res_r[7:3];
   assign out_g = l_noblend ? fg_g[7:3] : res_g[7:3];
   assign out_b = l_noblend ? fg_b[7:3] : res_b[7:3];

   logic unused_res_lsb;
   assign unused_res_lsb = ^{res_r[2:0], res_g[2:0], res_b[2:0]};

   assign bus.rd_addr    = l_addr;
   assign bus.wr_addr    = l_addr;
   assign bus.wr_data    = {l_force | l_stp, out_b, out_g, out_r};
   assign bus.bg_r       = {bg[4:0], 3'b000};
   assign bus.bg_g       = {bg[9:5], 3'b000};
   assign bus.bg_b       = {bg[14:10], 3'b000};
   assign bus.px_r       = fg_r;
   assign bus.px_g       = fg_g;
   assign bus.px_b       = fg_b;
   assign bus.dp_noblend = l_noblend;
   assign bus.dp_mode    = l_mode;
   assign bus.discard    = discard_q;
   assign bus.wr_count   = wr_cnt;
   assign bus.drop_count = drop_cnt;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_blend_rmw_sequencer.sv
// tb/tb_blend_rmw_sequencer.sv - directed self-checking bench for blend_rmw_sequencer
module tb_blend_rmw_sequencer;
   localparam int ADDR_W = 19;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   acc;

   always #5 clk = ~clk;

   blend_rmw_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   blend_rmw_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Saturating blend datapath: B/2+F/2, B+F, B-F, B+F/4.
   function automatic logic [7:0] blend(input logic [7:0] b, input logic [7:0] f, input logic [1:0] m);
      int s;
      case (m)
         2'd0:    s = int'(b) / 2 + int'(f) / 2;
         2'd1:    s = int'(b) + int'(f);
         2'd2:    s = int'(b) - int'(f);
         default: s = int'(b) + int'(f) / 4;
      endcase
      if (s < 0)   s = 0;
      if (s > 255) s = 255;
      return 8'(s);
   endfunction

   always_comb begin
      bus.bl_r = blend(bus.bg_r, bus.px_r, bus.dp_mode);
      bus.bl_g = blend(bus.bg_g, bus.px_g, bus.dp_mode);
      bus.bl_b = blend(bus.bg_b, bus.px_b, bus.dp_mode);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pixel(input logic [ADDR_W-1:0] addr, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic stp, input logic nb, input logic [1:0] m,
                              input logic cm, input logic fm);
      bus.pix_addr   = addr;
      bus.pix_r      = r;
      bus.pix_g      = g;
      bus.pix_b      = b;
      bus.pix_stp    = stp;
      bus.noblend    = nb;
      bus.mode       = m;
      bus.check_mask = cm;
      bus.force_mask = fm;
      bus.pix_valid  = 1'b1;
      tick();
      bus.pix_valid  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.pix_valid = 0; bus.pix_addr = '0; bus.pix_r = 0; bus.pix_g = 0; bus.pix_b = 0;
      bus.pix_stp = 0; bus.noblend = 0; bus.mode = 0; bus.check_mask = 0; bus.force_mask = 0;
      bus.rd_ack = 1; bus.rd_valid = 0; bus.rd_data = 0; bus.wr_ack = 1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus.pix_ready, 1);
      check("rst_rdreq", bus.rd_req, 0);
      check("rst_wrreq", bus.wr_req, 0);
      check("rst_discard", bus.discard, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_wrcnt", bus.wr_count, 0);
      check("rst_dropcnt", bus.drop_count, 0);
      check("rst_wrdata", bus.wr_data, 0);
      check("rst_rdaddr", bus.rd_addr, 0);
      check("rst_bg_r", bus.bg_r, 0);
      tick();
      rst = 0;
      tick();

      // 1: opaque write, no read
      drive_pixel(19'h00123, 8'hF8, 8'h00, 8'h08, 0, 1, 2'd0, 0, 0);
      @(negedge clk);
      check("t1_rdreq", bus.rd_req, 0);
      check("t1_wrreq", bus.wr_req, 1);
      check("t1_wrdata", bus.wr_data, 16'h041F);
      check("t1_wraddr", bus.wr_addr, 19'h00123);
      check("t1_ready", bus.pix_ready, 0);
      tick();
      @(negedge clk);
      check("t1_ready_t2", bus.pix_ready, 1);
      check("t1_wrcnt", bus.wr_count, 1);

      // 2: additive blend
      drive_pixel(19'h00456, 8'h40, 8'h40, 8'h40, 0, 0, 2'd1, 0, 0);
      @(negedge clk);
      check("t2_rdreq", bus.rd_req, 1);
      check("t2_rdaddr", bus.rd_addr, 19'h00456);
      tick();
      bus.rd_valid = 1; bus.rd_data = 16'h0421;
      tick();
      bus.rd_valid = 0;
      @(negedge clk);
      check("t2_bg_r", bus.bg_r, 8'h08);
      check("t2_bg_g", bus.bg_g, 8'h08);
      check("t2_bg_b", bus.bg_b, 8'h08);
      check("t2_px_r", bus.px_r, 8'h40);
      check("t2_mode", bus.dp_mode, 1);
      check("t2_noblend", bus.dp_noblend, 0);
      tick();
      @(negedge clk);
      check("t2_wrreq", bus.wr_req, 1);
      check("t2_wrdata", bus.wr_data, 16'h2529);
      tick();
      @(negedge clk);
      check("t2_wrcnt", bus.wr_count, 2);
      check("t2_ready", bus.pix_ready, 1);

      // 3: mask test discards
      drive_pixel(19'h00789, 8'h00, 8'h00, 8'h00, 0, 1, 2'd0, 1, 0);
      tick();
      bus.rd_valid = 1; bus.rd_data = 16'h8000;
      tick();
      bus.rd_valid = 0;
      @(negedge clk);
      check("t3_discard", bus.discard, 1);
      check("t3_wrreq", bus.wr_req, 0);
      check("t3_dropcnt", bus.drop_count, 1);
      check("t3_ready", bus.pix_ready, 1);
      tick();
      @(negedge clk);
      check("t3_discard_end", bus.discard, 0);
      check("t3_wrcnt", bus.wr_count, 2);

      // 3b: mask clear, opaque colour kept, forced mask bit
      drive_pixel(19'h0078A, 8'hF8, 8'hF8, 8'hF8, 0, 1, 2'd2, 1, 1);
      tick();
      bus.rd_valid = 1; bus.rd_data = 16'h7FFF;
      tick();
      bus.rd_valid = 0;
      tick();
      @(negedge clk);
      check("t3b_wrdata", bus.wr_data, 16'hFFFF);
      tick();
      @(negedge clk);
      check("t3b_wrcnt", bus.wr_count, 3);
      check("t3b_dropcnt", bus.drop_count, 1);

      // 4: stalled read ack and write ack, stray rd_valid before ack
      bus.rd_ack = 0; bus.wr_ack = 0;
      drive_pixel(19'h7FFFF, 8'h10, 8'h20, 8'h30, 1, 0, 2'd2, 0, 0);
      bus.rd_valid = 1; bus.rd_data = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_rdreq_hold", bus.rd_req, 1);
         check("t4_rdaddr_hold", bus.rd_addr, 19'h7FFFF);
         tick();
      end
      bus.rd_ack = 1; bus.rd_valid = 0;
      tick();
      bus.rd_ack = 0;
      @(negedge clk);
      check("t4_rdreq_drop", bus.rd_req, 0);
      tick();
      bus.rd_valid = 1; bus.rd_data = 16'h0A1F;
      tick();
      bus.rd_valid = 0;
      @(negedge clk);
      check("t4_bg_r", bus.bg_r, 8'hF8);
      check("t4_bg_g", bus.bg_g, 8'h80);
      check("t4_bg_b", bus.bg_b, 8'h10);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_wrreq_hold", bus.wr_req, 1);
         check("t4_wrdata_hold", bus.wr_data, 16'h819D);
         check("t4_wraddr_hold", bus.wr_addr, 19'h7FFFF);
         check("t4_wrcnt_hold", bus.wr_count, 3);
         tick();
      end
      bus.wr_ack = 1;
      tick();
      @(negedge clk);
      check("t4_wrcnt", bus.wr_count, 4);
      check("t4_wrreq_end", bus.wr_req, 0);

      // 5: reset in RDWAIT, then in WRITE
      bus.rd_ack = 1;
      drive_pixel(19'h00111, 8'h11, 8'h22, 8'h33, 0, 0, 2'd0, 0, 0);
      tick();
      rst = 1;
      #1;
      check("t5a_rdreq", bus.rd_req, 0);
      check("t5a_wrreq", bus.wr_req, 0);
      check("t5a_busy", bus.busy, 0);
      check("t5a_wrcnt", bus.wr_count, 0);
      check("t5a_dropcnt", bus.drop_count, 0);
      check("t5a_rdaddr", bus.rd_addr, 0);
      tick();
      rst = 0;
      @(negedge clk);
      check("t5a_ready", bus.pix_ready, 1);
      bus.wr_ack = 0;
      drive_pixel(19'h00222, 8'h11, 8'h22, 8'h33, 0, 1, 2'd0, 0, 0);
      @(negedge clk);
      check("t5b_wrreq_pre", bus.wr_req, 1);
      rst = 1;
      #1;
      check("t5b_wrreq", bus.wr_req, 0);
      check("t5b_wraddr", bus.wr_addr, 0);
      check("t5b_wrdata", bus.wr_data, 0);
      tick();
      rst = 0;
      bus.wr_ack = 1;
      @(negedge clk);
      check("t5b_ready", bus.pix_ready, 1);
      check("t5b_busy", bus.busy, 0);

      // 6: back-to-back opaque pixels, counter wrap
      tick();
      bus.noblend = 1; bus.check_mask = 0; bus.pix_addr = 19'h00333; bus.pix_valid = 1;
      acc = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (bus.pix_valid && bus.pix_ready) acc++;
      end
      @(posedge clk);
      #1;
      bus.pix_valid = 0;
      @(negedge clk);
      check("t6_accepts", acc, 16);
      check("t6_wrcnt_wrap", bus.wr_count, 0);
      check("t6_busy", bus.busy, 0);
      drive_pixel(19'h00334, 8'h08, 8'h08, 8'h08, 0, 1, 2'd0, 0, 0);
      tick();
      @(negedge clk);
      check("t6_wrcnt_after", bus.wr_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
